// File: rtl/sdu_uart_link_if.sv
// sdu_uart_link_if: DCP-facing bundle of the serial debug unit UART link.
// Carries the TX/RX byte handshakes, FIFO occupancy counts and sticky
// error flags. The master side is the debug command processor, the slave
// side is the UART link itself.
interface sdu_uart_link_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] tx_data;
    logic              tx_vld;
    logic              tx_rdy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_vld;
    logic              rx_rdy;
    logic [CW-1:0]     rx_cnt;
    logic [CW-1:0]     tx_cnt;
    logic              tx_busy;
    logic              rx_ovf;
    logic              frm_err;
    logic              par_err;
    logic              err_clr;

    modport master (
        output tx_data, tx_vld, rx_rdy, err_clr,
        input  tx_rdy, rx_data, rx_vld, rx_cnt, tx_cnt, tx_busy,
               rx_ovf, frm_err, par_err
    );

    modport slave (
        input  tx_data, tx_vld, rx_rdy, err_clr,
        output tx_rdy, rx_data, rx_vld, rx_cnt, tx_cnt, tx_busy,
               rx_ovf, frm_err, par_err
    );
endinterface

// File: rtl/sdu_uart_link.sv
// sdu_uart_link: parametrised UART link for the serial debug unit.
// A programmable baud tick drives an oversampled receiver (behind a
// 2-flop synchroniser) and a transmitter; both sides are buffered by
// first-word fall-through FIFOs towards the debug command processor.
// Optional feature macro: SDU_PARITY_EN adds one parity bit per frame,
// with the sense chosen by PARITY_ODD (0 = even, 1 = odd).
module sdu_uart_link #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVS        = 16,
    parameter int DIV_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             rxd,
    output logic             txd,
    sdu_uart_link_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (OVS < 4 || (OVS % 2) != 0) begin : g_bad_ovs
        $error("OVS must be even and at least 4");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("PARITY_ODD must be 0 or 1");
    end

`ifdef SDU_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} link_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} link_state_t;
`endif

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == baud_div);

    // Free-running divider that reloads on match, so a new baud_div applies at the next compare
    always_ff @(posedge clk) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    // ---------------- RX synchroniser ----------------
    logic rxd_m, rxd_s;

    // Two flops bring the asynchronous pin into the clk domain; reset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // ---------------- RX FSM ----------------
    link_state_t       rx_state, rx_state_n;
    logic [TW-1:0]     rx_tcnt, rx_tcnt_n;
    logic [BW-1:0]     rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic              rx_push, frm_evt;
`ifdef SDU_PARITY_EN
    logic              rx_par_bad, rx_par_bad_n, par_evt;
`endif

    // RX state, tick counter, bit index and assembled byte
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
`ifdef SDU_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
`ifdef SDU_PARITY_EN
            rx_par_bad <= rx_par_bad_n;
`endif
        end
    end

    // RX next state: start detect, mid-bit sampling, stop-bit verdict
    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        frm_evt    = 1'b0;
`ifdef SDU_PARITY_EN
        rx_par_bad_n = rx_par_bad;
        par_evt      = 1'b0;
`endif
        case (rx_state)
            IDLE: begin
                if (tick && !rxd_s) begin
                    rx_state_n = START;
                    rx_tcnt_n  = '0;
`ifdef SDU_PARITY_EN
                    rx_par_bad_n = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (rx_tcnt == T_HALF) begin
                        rx_tcnt_n  = '0;
                        rx_bit_n   = '0;
                        rx_state_n = rxd_s ? IDLE : DATA;
                    end else begin
                        rx_tcnt_n = rx_tcnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_tcnt == T_LAST) begin
                        rx_tcnt_n  = '0;
                        rx_shift_n = {rxd_s, rx_shift[DATA_W-1:1]};
                        if (rx_bit == B_LAST) begin
`ifdef SDU_PARITY_EN
                            rx_state_n = PAR;
`else
                            rx_state_n = STOP;
`endif
                        end else begin
                            rx_bit_n = rx_bit + BW'(1);
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + TW'(1);
                    end
                end
            end
`ifdef SDU_PARITY_EN
            PAR: begin
                if (tick) begin
                    if (rx_tcnt == T_LAST) begin
                        rx_tcnt_n    = '0;
                        rx_par_bad_n = (rxd_s != ((^rx_shift) ^ (PARITY_ODD != 0)));
                        rx_state_n   = STOP;
                    end else begin
                        rx_tcnt_n = rx_tcnt + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_tcnt == T_LAST) begin
                        rx_tcnt_n  = '0;
                        rx_state_n = IDLE;
                        frm_evt    = !rxd_s;
`ifdef SDU_PARITY_EN
                        par_evt = rx_par_bad;
                        rx_push = rxd_s && !rx_par_bad;
`else
                        rx_push = rxd_s;
`endif
                    end else begin
                        rx_tcnt_n = rx_tcnt + TW'(1);
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wptr, rx_rptr;
    logic [CW-1:0]     rx_cnt_q;
    logic              rx_full, rx_pop, rx_wr, rx_ovf_evt;

    assign rx_full     = (rx_cnt_q == C_FULL);
    assign rx_pop      = bus.rx_vld && bus.rx_rdy;
    assign rx_wr       = rx_push && (!rx_full || rx_pop);
    assign rx_ovf_evt  = rx_push && rx_full && !rx_pop;
    assign bus.rx_vld  = (rx_cnt_q != '0);
    assign bus.rx_data = rx_mem[rx_rptr];
    assign bus.rx_cnt  = rx_cnt_q;

    // RX storage write port; a dropped overflow byte never reaches it
    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wptr] <= rx_shift;
    end

    // RX pointers wrap naturally; the count saturates at FIFO_DEPTH by construction
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_wr)  rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop) rx_rptr <= rx_rptr + AW'(1);
            rx_cnt_q <= rx_cnt_q + CW'(rx_wr) - CW'(rx_pop);
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wptr, tx_rptr;
    logic [CW-1:0]     tx_cnt_q;
    logic              tx_empty, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;

    assign bus.tx_rdy = (tx_cnt_q != C_FULL);
    assign tx_push    = bus.tx_vld && bus.tx_rdy;
    assign tx_empty   = (tx_cnt_q == '0);
    assign tx_head    = tx_mem[tx_rptr];
    assign bus.tx_cnt = tx_cnt_q;

    // TX storage write port
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= bus.tx_data;
    end

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // ---------------- TX FSM ----------------
    link_state_t       tx_state, tx_state_n;
    logic [TW-1:0]     tx_tcnt, tx_tcnt_n;
    logic [BW-1:0]     tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic              txd_n;
`ifdef SDU_PARITY_EN
    logic              tx_par, tx_par_n;
`endif

    assign bus.tx_busy = (tx_state != IDLE);

    // TX state, counters, shift register and the registered pin driver
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
`ifdef SDU_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_tcnt  <= tx_tcnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd      <= txd_n;
`ifdef SDU_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // TX next state; a frame ending with data still queued reloads directly so frames abut
    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tx_tcnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        txd_n      = 1'b1;
`ifdef SDU_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            IDLE: begin
                if (tick && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_tcnt_n  = '0;
                    tx_state_n = START;
`ifdef SDU_PARITY_EN
                    tx_par_n   = (^tx_head) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (tx_tcnt == T_LAST) begin
                        tx_tcnt_n  = '0;
                        tx_bit_n   = '0;
                        tx_state_n = DATA;
                    end else begin
                        tx_tcnt_n = tx_tcnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_tcnt == T_LAST) begin
                        tx_tcnt_n  = '0;
                        tx_shift_n = tx_shift >> 1;
                        if (tx_bit == B_LAST) begin
`ifdef SDU_PARITY_EN
                            tx_state_n = PAR;
`else
                            tx_state_n = STOP;
`endif
                        end else begin
                            tx_bit_n = tx_bit + BW'(1);
                        end
                    end else begin
                        tx_tcnt_n = tx_tcnt + TW'(1);
                    end
                end
            end
`ifdef SDU_PARITY_EN
            PAR: begin
                if (tick) begin
                    if (tx_tcnt == T_LAST) begin
                        tx_tcnt_n  = '0;
                        tx_state_n = STOP;
                    end else begin
                        tx_tcnt_n = tx_tcnt + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tx_tcnt == T_LAST) begin
                        tx_tcnt_n = '0;
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_n = tx_head;
                            tx_state_n = START;
`ifdef SDU_PARITY_EN
                            tx_par_n   = (^tx_head) ^ (PARITY_ODD != 0);
`endif
                        end else begin
                            tx_state_n = IDLE;
                        end
                    end else begin
                        tx_tcnt_n = tx_tcnt + TW'(1);
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase

        case (tx_state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = tx_shift_n[0];
`ifdef SDU_PARITY_EN
            PAR:     txd_n = tx_par_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    // ---------------- sticky flags ----------------
    logic rx_ovf_q, frm_err_q;

    // Sticky error flags; an error event in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovf_q  <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            if (rx_ovf_evt)       rx_ovf_q <= 1'b1;
            else if (bus.err_clr) rx_ovf_q <= 1'b0;
            if (frm_evt)          frm_err_q <= 1'b1;
            else if (bus.err_clr) frm_err_q <= 1'b0;
        end
    end

    assign bus.rx_ovf  = rx_ovf_q;
    assign bus.frm_err = frm_err_q;

`ifdef SDU_PARITY_EN
    logic par_err_q;

    // Sticky parity error with the same event-wins priority as the other flags
    always_ff @(posedge clk) begin
        if (rst)              par_err_q <= 1'b0;
        else if (par_evt)     par_err_q <= 1'b1;
        else if (bus.err_clr) par_err_q <= 1'b0;
    end

    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdu_uart_link.sv
// tb_sdu_uart_link: directed bench for the serial debug unit UART link.
// Table-driven RX frames plus hand-written sequences for TX timing,
// loopback, overflow, glitch rejection, mid-frame reset and parity.
module tb_sdu_uart_link;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int OVS        = 16;
    localparam int DIV_W      = 16;
    localparam int PARITY_ODD = 0;
    localparam int BAUD       = 3;
    localparam int BIT_CLK    = OVS * (BAUD + 1);
`ifdef SDU_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 3;
`else
    localparam int FRAME_BITS = DATA_W + 2;
`endif
    localparam int FRAME_CLK  = FRAME_BITS * BIT_CLK;
    localparam int HIST       = FRAME_CLK + 200;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] baud_div;
    logic             rxd_drv;
    logic             loopback;
    logic             rxd;
    logic             txd;

    int errors;
    int checks;

    logic txd_hist  [HIST];
    logic busy_hist [HIST];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_push;
        logic       exp_frm;
    } rx_vec_t;

    rx_vec_t rx_vecs [6];

    assign rxd = loopback ? txd : rxd_drv;

    sdu_uart_link_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    sdu_uart_link #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OVS(OVS),
        .DIV_W(DIV_W), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .rxd(rxd), .txd(txd), .bus(bus)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one serial frame on rxd; par_flip inverts the parity bit when parity is built in
    task automatic applyStimulus(input logic [7:0] d, input logic stop_b, input logic par_flip);
        rxd_drv = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DATA_W; i++) begin
            rxd_drv = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef SDU_PARITY_EN
        rxd_drv = (^d) ^ (PARITY_ODD != 0) ^ par_flip;
        repeat (BIT_CLK) @(negedge clk);
`else
        if (par_flip) $display("[TB] parity flip ignored in a build without parity");
`endif
        rxd_drv = stop_b;
        repeat (BIT_CLK) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic popRx();
        bus.rx_rdy = 1'b1;
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic clearErrors();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic expTxBit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DATA_W) return d[k-1];
`ifdef SDU_PARITY_EN
        if (k == DATA_W + 1) return (^d) ^ (PARITY_ODD != 0);
`endif
        return 1'b1;
    endfunction

    initial begin
        int t0, b0, busy_n, low_run, idx, first_hi, last_hi;

        errors = 0;
        checks = 0;
        rst = 1'b1;
        baud_div = DIV_W'(BAUD);
        rxd_drv = 1'b1;
        loopback = 1'b0;
        bus.tx_data = '0;
        bus.tx_vld = 1'b0;
        bus.rx_rdy = 1'b0;
        bus.err_clr = 1'b0;

        rx_vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        rx_vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        rx_vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        rx_vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        rx_vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1};
        rx_vecs[5] = '{8'h42, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rst_txd",     txd,         1);
        checkOutput("rst_tx_rdy",  bus.tx_rdy,  1);
        checkOutput("rst_rx_vld",  bus.rx_vld,  0);
        checkOutput("rst_tx_busy", bus.tx_busy, 0);
        checkOutput("rst_rx_cnt",  bus.rx_cnt,  0);
        checkOutput("rst_tx_cnt",  bus.tx_cnt,  0);
        checkOutput("rst_rx_ovf",  bus.rx_ovf,  0);
        checkOutput("rst_frm_err", bus.frm_err, 0);
        checkOutput("rst_par_err", bus.par_err, 0);

        // Transmit timing for 0x55
        bus.tx_data = 8'h55;
        bus.tx_vld = 1'b1;
        @(negedge clk);
        bus.tx_vld = 1'b0;
        checkOutput("tx_cnt_after_push", bus.tx_cnt, 1);
        for (int i = 0; i < HIST; i++) begin
            txd_hist[i]  = txd;
            busy_hist[i] = bus.tx_busy;
            @(negedge clk);
        end
        t0 = -1; b0 = -1; busy_n = 0;
        for (int i = 0; i < HIST; i++) begin
            if (t0 < 0 && !txd_hist[i]) t0 = i;
            if (b0 < 0 && busy_hist[i]) b0 = i;
            if (busy_hist[i]) busy_n++;
        end
        checkOutput("tx_start_seen", t0 >= 0, 1);
        checkOutput("tx_busy_len", busy_n, FRAME_CLK);
        if (t0 >= 0) begin
            checkOutput("tx_busy_aligned", b0, t0);
            low_run = 0;
            idx = t0;
            while (idx < HIST && !txd_hist[idx]) begin
                low_run++;
                idx++;
            end
            checkOutput("tx_start_len", low_run, BIT_CLK);
            for (int k = 0; k < FRAME_BITS; k++) begin
                idx = t0 + BIT_CLK / 2 + k * BIT_CLK;
                if (idx < HIST) checkOutput($sformatf("tx_bit%0d", k), txd_hist[idx], expTxBit(8'h55, k));
                else checkOutput("tx_bit_in_window", idx, HIST - 1);
            end
        end
        checkOutput("tx_idle_after", txd, 1);

        // Loopback of two back-to-back frames
        loopback = 1'b1;
        bus.tx_data = 8'hA5;
        bus.tx_vld = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'h3C;
        @(negedge clk);
        bus.tx_vld = 1'b0;
        first_hi = -1; last_hi = -1; busy_n = 0;
        for (int i = 0; i < 2 * FRAME_CLK + 200; i++) begin
            if (bus.tx_busy) begin
                if (first_hi < 0) first_hi = i;
                last_hi = i;
                busy_n++;
            end
            @(negedge clk);
        end
        checkOutput("lb_busy_total", busy_n, 2 * FRAME_CLK);
        checkOutput("lb_no_gap", last_hi - first_hi + 1, 2 * FRAME_CLK);
        checkOutput("lb_rx_cnt", bus.rx_cnt, 2);
        checkOutput("lb_first", bus.rx_data, 8'hA5);
        popRx();
        checkOutput("lb_second", bus.rx_data, 8'h3C);
        popRx();
        checkOutput("lb_empty", bus.rx_vld, 0);
        loopback = 1'b0;
        repeat (8) @(negedge clk);

        // RX overflow: 17 frames with no consumer
        for (int v = 0; v <= FIFO_DEPTH; v++) applyStimulus(8'(v), 1'b1, 1'b0);
        checkOutput("ovf_rx_cnt", bus.rx_cnt, FIFO_DEPTH);
        checkOutput("ovf_flag", bus.rx_ovf, 1);
        checkOutput("ovf_tx_rdy", bus.tx_rdy, 1);
        for (int v = 0; v < FIFO_DEPTH; v++) begin
            checkOutput($sformatf("ovf_pop%0d", v), bus.rx_data, v);
            popRx();
        end
        checkOutput("ovf_drained", bus.rx_cnt, 0);
        clearErrors();
        checkOutput("ovf_cleared", bus.rx_ovf, 0);

        // Table-driven RX frames, including a framing error followed by a good frame
        foreach (rx_vecs[n]) begin
            applyStimulus(rx_vecs[n].data, rx_vecs[n].stop_bit, 1'b0);
            checkOutput($sformatf("vec%0d_cnt", n), bus.rx_cnt, rx_vecs[n].exp_push);
            checkOutput($sformatf("vec%0d_frm", n), bus.frm_err, rx_vecs[n].exp_frm);
            checkOutput($sformatf("vec%0d_par", n), bus.par_err, 0);
            if (rx_vecs[n].exp_push) begin
                checkOutput($sformatf("vec%0d_data", n), bus.rx_data, rx_vecs[n].data);
                popRx();
            end
            clearErrors();
            checkOutput($sformatf("vec%0d_clr", n), bus.frm_err, 0);
        end

        // Glitch shorter than half a bit is rejected, then a normal frame still lands
        rxd_drv = 1'b0;
        repeat (4 * (BAUD + 1)) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        checkOutput("glitch_cnt", bus.rx_cnt, 0);
        checkOutput("glitch_frm", bus.frm_err, 0);
        checkOutput("glitch_ovf", bus.rx_ovf, 0);
        applyStimulus(8'hC3, 1'b1, 1'b0);
        checkOutput("glitch_next_cnt", bus.rx_cnt, 1);
        checkOutput("glitch_next_data", bus.rx_data, 8'hC3);
        popRx();

        // Reset in the middle of a transmitted frame
        bus.tx_data = 8'h00;
        bus.tx_vld = 1'b1;
        @(negedge clk);
        bus.tx_vld = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("midrst_txd_low", txd, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_txd", txd, 1);
        checkOutput("midrst_busy", bus.tx_busy, 0);
        checkOutput("midrst_tx_cnt", bus.tx_cnt, 0);
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("midrst_stays_idle", txd, 1);

`ifdef SDU_PARITY_EN
        // Wrong parity drops the byte, correct parity delivers it
        applyStimulus(8'h07, 1'b1, 1'b1);
        checkOutput("par_bad_flag", bus.par_err, 1);
        checkOutput("par_bad_cnt", bus.rx_cnt, 0);
        checkOutput("par_bad_frm", bus.frm_err, 0);
        clearErrors();
        applyStimulus(8'h07, 1'b1, 1'b0);
        checkOutput("par_ok_flag", bus.par_err, 0);
        checkOutput("par_ok_cnt", bus.rx_cnt, 1);
        checkOutput("par_ok_data", bus.rx_data, 8'h07);
        popRx();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #3000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
